// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter.
// Merges ALU results and load responses into one registered write port.
// Loads are extended on entry and buffered in a 2-entry FIFO. Any FIFO
// entry ahead of an ALU result is drained first only when the FIFO is full.
// Optional feature macro: WB_FWD_EN adds decode-stage bypass outputs taken
// from the registered write port.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [2:0]      lsu_funct3,
    input  logic [1:0]      lsu_addr_lo,
    input  logic [XLEN-1:0] lsu_data,
`ifdef WB_FWD_EN
    input  logic [4:0]      src1_addr,
    input  logic [4:0]      src2_addr,
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic            rf_wen_n,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data
);

    // Extend a raw aligned load word according to the load type and offset.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
            default: load_ext = d;
        endcase
    endfunction

    logic [4:0]      fifo_rd   [2];
    logic [XLEN-1:0] fifo_data [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic            full;
    logic            push;
    logic            pop;
    logic            sel_alu;
    logic            sel_any;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Arbitration: a full FIFO must drain, otherwise ALU has priority.
    // Readiness depends only on the registered count, never on valids.
    always_comb begin
        full      = (count == 2'd2);
        alu_ready = !full;
        lsu_ready = !full;
        push      = lsu_valid && !full;
        sel_alu   = alu_valid && !full;
        pop       = full || (!alu_valid && (count != 2'd0));
        sel_any   = sel_alu || pop;
        sel_rd    = pop ? fifo_rd[rd_ptr]   : alu_rd;
        sel_data  = pop ? fifo_data[rd_ptr] : alu_data;
    end

    // FIFO storage: payload needs no reset, occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lsu_rd;
            fifo_data[wr_ptr] <= load_ext(lsu_data, lsu_funct3, lsu_addr_lo);
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Registered write port; writes to x0 are consumed without asserting the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen_n <= 1'b1;
            rf_rd    <= 5'd0;
            rf_data  <= '0;
        end else begin
            rf_wen_n <= !(sel_any && (sel_rd != 5'd0));
            if (sel_any && (sel_rd != 5'd0)) begin
                rf_rd   <= sel_rd;
                rf_data <= sel_data;
            end
        end
    end

`ifdef WB_FWD_EN
    // Bypass the value currently being written to decode-stage readers.
    always_comb begin
        fwd1_hit  = !rf_wen_n && (rf_rd == src1_addr) && (src1_addr != 5'd0);
        fwd2_hit  = !rf_wen_n && (rf_rd == src2_addr) && (src2_addr != 5'd0);
        fwd1_data = fwd1_hit ? rf_data : '0;
        fwd2_data = fwd2_hit ? rf_data : '0;
    end
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have clk, input, 1, rising-edge clock.
REQ-003 SHALL have rst_n, input, 1, reset (synchronous, active-low; clock clk).
REQ-004 SHALL have alu_valid/alu_ready, input/output, 1/1, ALU result handshake.
REQ-005 SHALL have alu_rd/alu_data, input, 5/XLEN, ALU destination and result.
REQ-006 SHALL have lsu_valid/lsu_ready, input/output, 1/1, load response handshake.
REQ-007 SHALL have lsu_rd/lsu_funct3/lsu_addr_lo, input, 5/3/2, load destination, load type, byte offset.
REQ-008 SHALL have lsu_data, input, XLEN, raw aligned load word.
REQ-009 SHALL have rf_wen_n, output, 1, register-file write enable, active-low.
REQ-010 SHALL have rf_rd/rf_data, output, 5/XLEN, register-file write address and data.
REQ-011 SHALL have src1_addr/src2_addr, input, 5/5, decode read addresses (WB_FWD_EN only).
REQ-012 SHALL have fwd1_hit/fwd1_data/fwd2_hit/fwd2_data, output, 1/XLEN/1/XLEN, bypass results (WB_FWD_EN only).

Function
REQ-013 SHALL accept an ALU transfer when alu_valid && alu_ready, and a load transfer when lsu_valid && lsu_ready.
REQ-014 SHALL buffer accepted loads in a 2-entry FIFO; lsu_ready = FIFO not full (count<2), from registered count only.
REQ-015 SHALL extend loads at FIFO push: funct3 000 LB, 100 LBU select byte lsu_addr_lo; 001 LH, 101 LHU select halfword lsu_addr_lo[1]; 010 LW whole word; LB/LH sign-extend, LBU/LHU zero-extend; any other funct3 passes lsu_data unmodified.
REQ-016 SHALL issue at most one write per cycle: FIFO full -> FIFO head wins, alu_ready=0; else alu_valid -> ALU wins, alu_ready=1; else FIFO non-empty -> head pops.
REQ-017 SHALL keep alu_ready=1 whenever FIFO count<2, regardless of alu_valid.
REQ-018 SHALL register the selected write: rf_wen_n=0, rf_rd, rf_data valid the cycle after selection; ALU latency 1 cycle, load latency 2 cycles minimum.
REQ-019 SHALL hold rf_wen_n=1 in cycles with no selected write; rf_rd/rf_data then hold previous values.
REQ-020 SHALL consume writes with rd=0 normally but drive rf_wen_n=1 for them.
REQ-021 SHALL allow push and pop in the same cycle (count unchanged); a load pushed into an empty FIFO is not poppable until the next cycle.
REQ-022 SHALL preserve per-source order; loads drain in acceptance order with FIFO pointers wrapping modulo 2.

Reset
REQ-023 SHALL on rst_n=0 at a clk edge: FIFO count and pointers 0, rf_wen_n=1, rf_rd=0, rf_data=0, fwd*_hit=0; in-flight and buffered writes are discarded.
REQ-024 SHALL drive lsu_ready=1 and alu_ready=1 in the first cycle after reset release.

Configuration
REQ-025 SHALL with WB_FWD_EN defined, drive fwdN_hit=1 and fwdN_data=rf_data combinationally when rf_wen_n=0 && rf_rd==srcN_addr && srcN_addr!=0, else hit=0 and data=0.
REQ-026 SHALL without WB_FWD_EN omit src1_addr, src2_addr and all fwd* ports and logic; other behaviour unchanged.

Verification
REQ-027 SHALL cover ALU only: alu_rd=5, alu_data=0x1234 -> next cycle rf_wen_n=0, rf_rd=5, rf_data=0x1234.
REQ-028 SHALL cover load extension: lsu_data=0x80FF7F01, LB offset 3 -> 0xFFFFFF80; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01.
REQ-029 SHALL cover contention: alu_valid held 1 with 3 back-to-back loads -> lsu_ready=0 after 2 accepted, then alu_ready=0 one cycle while FIFO head writes; no write lost or reordered.
REQ-030 SHALL cover rd=0: alu_rd=0, alu_data=0xDEAD -> alu_ready=1, rf_wen_n stays 1.
REQ-031 SHALL cover reset mid-operation: FIFO holding 2 loads, rst_n=0 one cycle -> no further rf_wen_n=0 pulses, lsu_ready=1 after release.
REQ-032 SHALL cover WB_FWD_EN: rf_wen_n=0, rf_rd=7, rf_data=0x55, src1_addr=7, src2_addr=0 -> fwd1_hit=1, fwd1_data=0x55, fwd2_hit=0.
